// File: rtl/unidade_controle_param.sv
// Step-sequenced control unit for the mv/mvi/add/sub datapath.
// Decodes the IR into register, ALU and bus enables over T0..T3.
module unidade_controle_param #(
  parameter int NREG     = 8,
  parameter int REG_BITS = 3,
  parameter int OPC_BITS = 3,
  localparam int IW      = OPC_BITS + 2 * REG_BITS
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [IW-1:0]   Instrucao,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            AddSub,
  output logic            DINout,
  output logic            Done,
  output logic            Busy,
  output logic            Illegal,
  output logic [1:0]      Tstep
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;

  localparam logic [OPC_BITS-1:0] OP_MV  = OPC_BITS'(0);
  localparam logic [OPC_BITS-1:0] OP_MVI = OPC_BITS'(1);
  localparam logic [OPC_BITS-1:0] OP_ADD = OPC_BITS'(2);
  localparam logic [OPC_BITS-1:0] OP_SUB = OPC_BITS'(3);

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [OPC_BITS-1:0] opc;
  logic [REG_BITS-1:0] rx;
  logic [REG_BITS-1:0] ry;
  logic [NREG-1:0]     rx_oh;
  logic [NREG-1:0]     ry_oh;
  logic                rx_ok;
  logic                ry_ok;
  logic [2:0]          fin_st;

  assign opc = Instrucao[IW-1 -: OPC_BITS];
  assign rx  = Instrucao[2*REG_BITS-1 -: REG_BITS];
  assign ry  = Instrucao[REG_BITS-1:0];

  assign rx_ok = int'(rx) < NREG;
  assign ry_ok = int'(ry) < NREG;

  always_comb begin
    rx_oh = '0;
    ry_oh = '0;
    for (int i = 0; i < NREG; i++) begin
      rx_oh[i] = (int'(rx) == i);
      ry_oh[i] = (int'(ry) == i);
    end
  end

  // A finishing step chains straight into the next fetch when Run is held.
  assign fin_st = Run ? S_T0 : S_IDLE;

  always_comb begin
    state_d = state_q;
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    AddSub  = 1'b0;
    DINout  = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    Tstep   = 2'b00;
    Busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        Busy = 1'b0;
        if (Run) state_d = S_T0;
      end
      S_T0: begin
        IRin    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Tstep = 2'b01;
        if (opc == OP_MV && rx_ok && ry_ok) begin
          Rin     = rx_oh;
          Rout    = ry_oh;
          Done    = 1'b1;
          state_d = fin_st;
        end else if (opc == OP_MVI && rx_ok) begin
          DINout  = 1'b1;
          Rin     = rx_oh;
          Done    = 1'b1;
          state_d = fin_st;
        end else if ((opc == OP_ADD || opc == OP_SUB)
                     && rx_ok && ry_ok) begin
          Rout    = rx_oh;
          Ain     = 1'b1;
          state_d = S_T2;
        end else begin
          Done    = 1'b1;
          Illegal = 1'b1;
          state_d = fin_st;
        end
      end
      S_T2: begin
        Tstep   = 2'b10;
        Rout    = ry_oh;
        Gin     = 1'b1;
        AddSub  = (opc == OP_SUB);
        state_d = S_T3;
      end
      S_T3: begin
        Tstep   = 2'b11;
        Gout    = 1'b1;
        Rin     = rx_oh;
        Done    = 1'b1;
        state_d = fin_st;
      end
      default: begin
        Busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
// Directed-vector bench for unidade_controle_param.
// Runs an NREG=8 instance plus an NREG=6 instance for range checks.
module tb_unidade_controle_param;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Run   = 1'b0;
  logic       Run6  = 1'b0;
  logic [8:0] Instrucao = '0;

  logic       IRin, Ain, Gin, Gout, AddSub, DINout;
  logic       Done, Busy, Illegal;
  logic [7:0] Rin, Rout;
  logic [1:0] Tstep;

  logic       IRin6, Ain6, Gin6, Gout6, AddSub6, DINout6;
  logic       Done6, Busy6, Illegal6;
  logic [5:0] Rin6, Rout6;
  logic [1:0] Tstep6;

  int nvec = 0;
  int nerr = 0;

  always #5 Clock = ~Clock;

  unidade_controle_param u_dut (
    .Clock(Clock), .Reset(Reset), .Run(Run),
    .Instrucao(Instrucao),
    .IRin(IRin), .Rin(Rin), .Rout(Rout),
    .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .AddSub(AddSub), .DINout(DINout),
    .Done(Done), .Busy(Busy),
    .Illegal(Illegal), .Tstep(Tstep)
  );

  unidade_controle_param #(.NREG(6)) u_dut6 (
    .Clock(Clock), .Reset(Reset), .Run(Run6),
    .Instrucao(Instrucao),
    .IRin(IRin6), .Rin(Rin6), .Rout(Rout6),
    .Ain(Ain6), .Gin(Gin6), .Gout(Gout6),
    .AddSub(AddSub6), .DINout(DINout6),
    .Done(Done6), .Busy(Busy6),
    .Illegal(Illegal6), .Tstep(Tstep6)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // reset with Run high, two edges
    Reset = 1'b1; Run = 1'b1;
    step(); step();
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_tstep", 32'(Tstep), 0);
    chk("rst_irin", 32'(IRin), 0);
    chk("rst_rin", 32'(Rin), 0);
    chk("rst_rout", 32'(Rout), 0);
    chk("rst_done", 32'(Done), 0);
    Reset = 1'b0;
    step();
    chk("rel_irin", 32'(IRin), 1);
    chk("rel_busy", 32'(Busy), 1);
    Run = 1'b0; Instrucao = 9'b001_000_000;
    step();
    chk("rel_done", 32'(Done), 1);
    step();
    chk("rel_idle", 32'(Busy), 0);

    // mv R3,R5
    Instrucao = 9'b000_011_101; Run = 1'b1;
    step();
    chk("mv_t0_irin", 32'(IRin), 1);
    chk("mv_t0_tstep", 32'(Tstep), 0);
    Run = 1'b0;
    step();
    chk("mv_rin", 32'(Rin), 32'h08);
    chk("mv_rout", 32'(Rout), 32'h20);
    chk("mv_done", 32'(Done), 1);
    chk("mv_ill", 32'(Illegal), 0);
    chk("mv_tstep", 32'(Tstep), 1);
    step();
    chk("mv_idle", 32'(Busy), 0);
    chk("mv_idle_done", 32'(Done), 0);

    // mvi R7
    Instrucao = 9'b001_111_000; Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    chk("mvi_din", 32'(DINout), 1);
    chk("mvi_rin", 32'(Rin), 32'h80);
    chk("mvi_rout", 32'(Rout), 0);
    chk("mvi_done", 32'(Done), 1);
    step();

    // sub R2,R6
    Instrucao = 9'b011_010_110; Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    chk("sub_t1_rout", 32'(Rout), 32'h04);
    chk("sub_t1_ain", 32'(Ain), 1);
    chk("sub_t1_done", 32'(Done), 0);
    step();
    chk("sub_t2_rout", 32'(Rout), 32'h40);
    chk("sub_t2_gin", 32'(Gin), 1);
    chk("sub_t2_as", 32'(AddSub), 1);
    chk("sub_t2_tstep", 32'(Tstep), 2);
    step();
    chk("sub_t3_gout", 32'(Gout), 1);
    chk("sub_t3_rin", 32'(Rin), 32'h04);
    chk("sub_t3_rout", 32'(Rout), 0);
    chk("sub_t3_done", 32'(Done), 1);
    chk("sub_t3_tstep", 32'(Tstep), 3);
    step();
    chk("sub_idle", 32'(Busy), 0);

    // add R0,R1 then mv R1,R0 with Run held
    Instrucao = 9'b010_000_001; Run = 1'b1;
    step();
    step();
    chk("add_t1_rout", 32'(Rout), 32'h01);
    step();
    chk("add_t2_rout", 32'(Rout), 32'h02);
    chk("add_t2_as", 32'(AddSub), 0);
    step();
    chk("add_t3_rin", 32'(Rin), 32'h01);
    chk("add_t3_done", 32'(Done), 1);
    step();
    chk("b2b_irin", 32'(IRin), 1);
    chk("b2b_busy", 32'(Busy), 1);
    Instrucao = 9'b000_001_000; Run = 1'b0;
    step();
    chk("b2b_mv_rin", 32'(Rin), 32'h02);
    chk("b2b_mv_rout", 32'(Rout), 32'h01);
    chk("b2b_mv_done", 32'(Done), 1);
    step();
    chk("b2b_idle", 32'(Busy), 0);

    // illegal opcode 111
    Instrucao = 9'b111_001_010; Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    chk("ill_done", 32'(Done), 1);
    chk("ill_flag", 32'(Illegal), 1);
    chk("ill_en", 32'({Rin, Rout, Ain, DINout, Gin, Gout}), 0);
    step();
    chk("ill_idle", 32'(Illegal), 0);

    // NREG=6 with Rx=7
    Instrucao = 9'b000_111_000; Run6 = 1'b1;
    step();
    Run6 = 1'b0;
    step();
    chk("n6_ill", 32'(Illegal6), 1);
    chk("n6_done", 32'(Done6), 1);
    chk("n6_rin", 32'(Rin6), 0);
    step();
    Instrucao = 9'b001_101_000; Run6 = 1'b1;
    step();
    Run6 = 1'b0;
    step();
    chk("n6_ok_ill", 32'(Illegal6), 0);
    chk("n6_ok_rin", 32'(Rin6), 32'h20);
    step();

    // reset during T2 aborts with no Done
    Instrucao = 9'b010_001_001; Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    step();
    chk("abt_t2_tstep", 32'(Tstep), 2);
    Reset = 1'b1;
    settle();
    chk("abt_t2_done", 32'(Done), 0);
    step();
    chk("abt_busy", 32'(Busy), 0);
    chk("abt_done", 32'(Done), 0);
    chk("abt_tstep", 32'(Tstep), 0);
    Reset = 1'b0;
    step();
    chk("abt_stay", 32'(Busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
